// File: rtl/regread_stage.sv
// Two-stage register-read pipeline between the issue queue and execute.
// Optional writeback bypass into both stages is enabled by defining REGREAD_BYPASS_EN.
module regread_stage #(
  parameter int unsigned WIDTH_REG = 5,
  parameter int unsigned WIDTH_TAG = 5,
  parameter int unsigned WIDTH_BRM = 3,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned WIDTH_I   = 7 + WIDTH_BRM + WIDTH_TAG + 2 + 3 * WIDTH_REG
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH_I-1:0]   i_inst,
  input  logic                 i_valid,
  output logic                 o_en,
  output logic [WIDTH_REG-1:0] o_rs1_addr,
  output logic [WIDTH_REG-1:0] o_rs2_addr,
  input  logic [XLEN-1:0]      i_rs1_data,
  input  logic [XLEN-1:0]      i_rs2_data,
  input  logic                 i_wb_en,
  input  logic [WIDTH_REG-1:0] i_wb_dest,
  input  logic [XLEN-1:0]      i_wb_data,
  input  logic [WIDTH_BRM:0]   i_BrKill,
  output logic                 o_valid,
  output logic [WIDTH_I-1:0]   o_inst,
  output logic [XLEN-1:0]      o_op1,
  output logic [XLEN-1:0]      o_op2,
  input  logic                 i_ready
);

  localparam int unsigned BRM_LO = 3 * WIDTH_REG + 2 + WIDTH_TAG;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH_I-1:0] s1_inst_q, s1_inst_d;
  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH_I-1:0] s2_inst_q, s2_inst_d;
  logic [XLEN-1:0]    s2_op1_q, s2_op1_d, s2_op2_q, s2_op2_d;

  logic                 adv1, adv2;
  logic                 kill_en;
  logic [WIDTH_BRM-1:0] kill_mask;
  logic                 in_kill, s1_kill, s2_kill;
  logic [WIDTH_REG-1:0] s1_rs1, s1_rs2, s2_rs1, s2_rs2;
  logic [XLEN-1:0]      rd_op1, rd_op2, hold_op1, hold_op2;

  assign kill_en   = i_BrKill[WIDTH_BRM];
  assign kill_mask = i_BrKill[WIDTH_BRM-1:0];
  assign in_kill   = kill_en && ((i_inst[BRM_LO +: WIDTH_BRM] & kill_mask) != '0);
  assign s1_kill   = kill_en && ((s1_inst_q[BRM_LO +: WIDTH_BRM] & kill_mask) != '0);
  assign s2_kill   = kill_en && ((s2_inst_q[BRM_LO +: WIDTH_BRM] & kill_mask) != '0);

  assign s1_rs2 = s1_inst_q[WIDTH_REG-1:0];
  assign s1_rs1 = s1_inst_q[2*WIDTH_REG-1:WIDTH_REG];
  assign s2_rs2 = s2_inst_q[WIDTH_REG-1:0];
  assign s2_rs1 = s2_inst_q[2*WIDTH_REG-1:WIDTH_REG];

  assign adv2 = !s2_valid_q || i_ready;
  assign adv1 = !s1_valid_q || adv2;

`ifndef REGREAD_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{i_wb_en, i_wb_dest, i_wb_data};
`endif

  // Register 0 override is applied last so it wins over any bypass.
  always_comb begin
    rd_op1   = i_rs1_data;
    rd_op2   = i_rs2_data;
    hold_op1 = s2_op1_q;
    hold_op2 = s2_op2_q;
`ifdef REGREAD_BYPASS_EN
    if (i_wb_en && i_wb_dest == s1_rs1) rd_op1 = i_wb_data;
    if (i_wb_en && i_wb_dest == s1_rs2) rd_op2 = i_wb_data;
    if (i_wb_en && i_wb_dest == s2_rs1 && s2_rs1 != '0) hold_op1 = i_wb_data;
    if (i_wb_en && i_wb_dest == s2_rs2 && s2_rs2 != '0) hold_op2 = i_wb_data;
`endif
    if (s1_rs1 == '0) rd_op1 = '0;
    if (s1_rs2 == '0) rd_op2 = '0;
  end

  always_comb begin
    s1_valid_d = s1_valid_q && !s1_kill;
    s1_inst_d  = s1_inst_q;
    if (adv1) begin
      s1_valid_d = i_valid && !in_kill;
      if (i_valid) s1_inst_d = i_inst;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q && !s2_kill;
    s2_inst_d  = s2_inst_q;
    s2_op1_d   = hold_op1;
    s2_op2_d   = hold_op2;
    if (adv2) begin
      s2_valid_d = s1_valid_q && !s1_kill;
      if (s1_valid_q) begin
        s2_inst_d = s1_inst_q;
        s2_op1_d  = rd_op1;
        s2_op2_d  = rd_op2;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_inst_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_inst_q  <= '0;
      s2_op1_q   <= '0;
      s2_op2_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_inst_q  <= s1_inst_d;
      s2_valid_q <= s2_valid_d;
      s2_inst_q  <= s2_inst_d;
      s2_op1_q   <= s2_op1_d;
      s2_op2_q   <= s2_op2_d;
    end
  end

  assign o_en       = adv1;
  assign o_rs1_addr = s1_rs1;
  assign o_rs2_addr = s1_rs2;
  assign o_valid    = s2_valid_q;
  assign o_inst     = s2_inst_q;
  assign o_op1      = s2_op1_q;
  assign o_op2      = s2_op2_q;

endmodule

// File: tb/tb_regread_stage.sv
// Directed self-checking bench for regread_stage; register file modelled as a fixed
// address-to-data map (address 0 returns 0xDEADBEEF to exercise the x0 override).
module tb_regread_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_inst;
  logic        i_valid;
  logic        o_en;
  logic [4:0]  o_rs1_addr, o_rs2_addr;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic        i_wb_en;
  logic [4:0]  i_wb_dest;
  logic [31:0] i_wb_data;
  logic [3:0]  i_BrKill;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_op1, o_op2;
  logic        i_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;

  regread_stage #(.WIDTH_REG(5), .WIDTH_TAG(5), .WIDTH_BRM(3), .XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inst(i_inst), .i_valid(i_valid), .o_en(o_en),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_wb_en(i_wb_en), .i_wb_dest(i_wb_dest), .i_wb_data(i_wb_data),
    .i_BrKill(i_BrKill), .o_valid(o_valid), .o_inst(o_inst),
    .o_op1(o_op1), .o_op2(o_op2), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    i_rs1_data = (o_rs1_addr == 5'd0) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(o_rs1_addr));
    i_rs2_data = (o_rs2_addr == 5'd0) ? 32'hDEAD_BEEF : (32'hB000_0000 | 32'(o_rs2_addr));
  end

  function automatic logic [31:0] mk(input logic [2:0] brm, input logic [4:0] tag,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h33, brm, tag, 2'b01, tag, rs1, rs2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic [31:0] inst0, inst1, inst2, inst3, k1, k2, b0;
  logic [31:0] exp_byp;

  initial begin
    inst0 = mk(3'b000, 5'd1, 5'd2, 5'd3);
    inst1 = mk(3'b000, 5'd2, 5'd4, 5'd5);
    inst2 = mk(3'b000, 5'd3, 5'd0, 5'd6);
    inst3 = mk(3'b000, 5'd4, 5'd7, 5'd8);
    k2    = mk(3'b001, 5'd5, 5'd9, 5'd10);
    k1    = mk(3'b010, 5'd6, 5'd11, 5'd12);
    b0    = mk(3'b000, 5'd7, 5'd3, 5'd7);

    i_rst_n = 1'b0; i_inst = '0; i_valid = 1'b0; i_ready = 1'b1;
    i_wb_en = 1'b0; i_wb_dest = '0; i_wb_data = '0; i_BrKill = '0;
    #3;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_op1", o_op1, 32'd0);
    chk("rst_op2", o_op2, 32'd0);
    chk("rst_addr", {o_rs1_addr, o_rs2_addr}, 32'd0);
    chk("rst_en", 32'(o_en), 32'd1);
    #9 i_rst_n = 1'b1;
    tick();

    // Full-throughput stream
    i_valid = 1'b1; i_inst = inst0;
    chk("str_en0", 32'(o_en), 32'd1);
    tick();
    chk("str_lat", 32'(o_valid), 32'd0);
    chk("str_addr", {27'd0, o_rs1_addr}, 32'd2);
    i_inst = inst1;
    tick();
    chk("str_v0", 32'(o_valid), 32'd1);
    chk("str_i0", o_inst, inst0);
    chk("str_a0", o_op1, 32'hA000_0002);
    chk("str_b0", o_op2, 32'hB000_0003);
    chk("str_en1", 32'(o_en), 32'd1);
    i_inst = inst2;
    tick();
    chk("str_i1", o_inst, inst1);
    chk("str_a1", o_op1, 32'hA000_0004);
    chk("str_b1", o_op2, 32'hB000_0005);
    i_inst = inst3;
    tick();
    chk("str_i2", o_inst, inst2);
    chk("str_x0", o_op1, 32'd0);
    chk("str_b2", o_op2, 32'hB000_0006);
    i_valid = 1'b0;
    tick();
    chk("str_i3", o_inst, inst3);
    chk("str_a3", o_op1, 32'hA000_0007);
    chk("str_v3", 32'(o_valid), 32'd1);
    tick();
    chk("str_empty", 32'(o_valid), 32'd0);

    // Back-pressure: fill both stages, hold for three cycles, then drain
    i_ready = 1'b0; i_valid = 1'b1; i_inst = inst0;
    tick();
    i_inst = inst1;
    tick();
    i_inst = inst2;
    chk("bp_en0", 32'(o_en), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_en", 32'(o_en), 32'd0);
      chk("bp_inst", o_inst, inst0);
      chk("bp_op1", o_op1, 32'hA000_0002);
      chk("bp_op2", o_op2, 32'hB000_0003);
      chk("bp_addr", {27'd0, o_rs1_addr}, 32'd4);
    end
    i_ready = 1'b1;
    #1;
    chk("bp_release_en", 32'(o_en), 32'd1);
    tick();
    chk("bp_d1", o_inst, inst1);
    chk("bp_d1op", o_op2, 32'hB000_0005);
    i_valid = 1'b0;
    tick();
    chk("bp_d2", o_inst, inst2);
    chk("bp_d2v", 32'(o_valid), 32'd1);
    tick();
    chk("bp_done", 32'(o_valid), 32'd0);

    // Branch kill: S1 mask 010 squashed, S2 mask 001 survives
    i_valid = 1'b1; i_inst = k2;
    tick();
    i_inst = k1; i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    chk("kl_pre", o_inst, k2);
    i_BrKill = 4'b1010;
    tick();
    i_BrKill = '0;
    chk("kl_s2v", 32'(o_valid), 32'd1);
    chk("kl_s2i", o_inst, k2);
    chk("kl_en", 32'(o_en), 32'd1);
    i_ready = 1'b1;
    chk("kl_op1", o_op1, 32'hA000_0009);
    tick();
    chk("kl_s1gone", 32'(o_valid), 32'd0);
    i_valid = 1'b1; i_inst = k1; i_BrKill = 4'b1010;
    tick();
    i_valid = 1'b0; i_BrKill = '0;
    tick();
    chk("kl_incoming", 32'(o_valid), 32'd0);

    // Writeback into a stalled S2
    i_ready = 1'b0; i_valid = 1'b1; i_inst = b0;
    tick();
    i_valid = 1'b0;
    tick();
    chk("by_pre", o_op2, 32'hB000_0007);
    i_wb_en = 1'b1; i_wb_dest = 5'd7; i_wb_data = 32'h55;
    tick();
    i_wb_en = 1'b0;
`ifdef REGREAD_BYPASS_EN
    exp_byp = 32'h55;
`else
    exp_byp = 32'hB000_0007;
`endif
    chk("by_op2", o_op2, exp_byp);
    chk("by_op1", o_op1, 32'hA000_0003);
    chk("by_inst", o_inst, b0);
    i_ready = 1'b1;
    tick();
    chk("by_drain", 32'(o_valid), 32'd0);

    // Reset with both stages full
    i_ready = 1'b0; i_valid = 1'b1; i_inst = inst0;
    tick();
    i_inst = inst1;
    tick();
    i_valid = 1'b0;
    chk("mr_full", 32'(o_valid), 32'd1);
    chk("mr_en_full", 32'(o_en), 32'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(o_valid), 32'd0);
    chk("mr_inst", o_inst, 32'd0);
    chk("mr_en", 32'(o_en), 32'd1);
    i_rst_n = 1'b1;
    tick();
    chk("mr_after_v", 32'(o_valid), 32'd0);
    chk("mr_after_en", 32'(o_en), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regread_stage.md
# regread_stage

Two-stage register-read pipeline directly downstream of the 4-in/1-out issue queue. Captures the single instruction granted by the queue, reads both source operands from the physical register file, optionally bypasses writeback data, and presents instruction plus operands to the execute unit through a valid/ready handshake. Back-pressure is returned to the queue through `o_en`, which drives the queue's enable. Branch-kill squashes in-flight entries in both stages.

## Interface
- `WIDTH_REG`, 5: physical register index width
- `WIDTH_TAG`, 5: ROB tag width
- `WIDTH_BRM`, 3: branch-mask width
- `XLEN`, 32: operand data width
- `WIDTH_I`, 7+WIDTH_BRM+WIDTH_TAG+2+3*WIDTH_REG: instruction width, equal to the queue output width; field order MSB→LSB {op[6:0], brmask, tag, ctl[1:0], rd, rs1, rs2}

- `i_clk` in 1: clock
- `i_rst_n` in 1: asynchronous active-low reset
- `i_inst` in WIDTH_I: instruction from issue queue
- `i_valid` in 1: queue has a granted instruction (queue ready)
- `o_en` out 1: stage accepts an instruction this cycle; drives queue enable
- `o_rs1_addr`, `o_rs2_addr` out WIDTH_REG: register-file read addresses (from stage 1)
- `i_rs1_data`, `i_rs2_data` in XLEN: register-file read data, combinational from addresses
- `i_wb_en` in 1, `i_wb_dest` in WIDTH_REG, `i_wb_data` in XLEN: writeback port
- `i_BrKill` in WIDTH_BRM+1: {enKill, BranchMask}
- `o_valid` out 1, `o_inst` out WIDTH_I, `o_op1`/`o_op2` out XLEN: to execute
- `i_ready` in 1: execute accepts

## Operation
- Stage 1 (S1): valid bit + instruction. Stage 2 (S2): valid bit + instruction + op1 + op2.
- `adv2 = !s2_valid | i_ready`; `adv1 = !s1_valid | adv2`; `o_en = adv1`.
- Accept: on edge with `o_en & i_valid`, S1 loads `i_inst`, s1_valid←1; `o_en & !i_valid` clears s1_valid.
- S1→S2 on edge with `adv2`: S2 takes S1 instruction and operands; s2_valid←s1_valid.
- `o_rs1_addr/o_rs2_addr` = S1 rs1/rs2 fields, held while S1 stalls.
- Register 0 reads as zero: operand forced to 0 when source index is 0, regardless of file data or bypass.
- Kill: when enKill=1, any entry with `(brmask & BranchMask) != 0` is invalidated at that edge in S1 and S2; the incoming `i_inst` is subject to the same test and is not loaded as valid if matched. Kill overrides hold and advance. Surviving entries keep their brmask unchanged.
- Simultaneous S2 handoff and S1 refill in one edge is supported (full throughput: one instruction per cycle).
- `o_valid=s2_valid`; outputs stable while `o_valid & !i_ready`.

## Timing
- Reset (async): s1_valid=0, s2_valid=0, `o_valid`=0, `o_inst`=0, `o_op1`=`o_op2`=0, address outputs=0; `o_en`=1 after reset (both stages empty).
- Latency: instruction accepted at edge N appears with `o_valid=1` after edge N+1 (2 edges queue→execute).
- `o_en` is combinational from `i_ready` and valid bits; no combinational path from `i_valid` to `o_en`.
- Reset asserted mid-operation discards all entries immediately; no partial handshake completes.

## Configuration
- `REGREAD_BYPASS_EN` defined: on S1→S2 transfer, if `i_wb_en` and `i_wb_dest` equals nonzero rs1/rs2, `i_wb_data` replaces file data; while S2 holds (stalled), a matching writeback also overwrites the held operand.
- Undefined: operands come only from the register file at S1→S2; register file is write-before-read same cycle; S2 operands never change while held.

## Test plan
- Stream 4 instructions, i_valid=1, i_ready=1 → o_en stays 1, each appears on o_valid 2 edges after accept, one per cycle, operands = file data.
- rs1=0 with i_rs1_data=0xDEADBEEF → o_op1=0.
- i_ready=0 for 3 cycles with both stages full → o_en=0, o_inst/o_op1/o_op2 constant; release → drain in order, no loss or duplication.
- S1 brmask=3'b010, S2 brmask=3'b001, i_BrKill=4'b1010 → S1 squashed, S2 survives and is delivered.
- With `REGREAD_BYPASS_EN`: S2 stalled holding rs2=7, writeback dest 7 data 0x55 → o_op2 becomes 0x55 next edge; without macro → o_op2 unchanged.
- Assert i_rst_n low with both stages valid → o_valid=0 immediately, o_en=1 after release.
